// File: rtl/max_pool_stream.sv
// Streaming max/min reduction over windows of fixed-point words with argmax index,
// element count and valid/ready handshakes on both sides.
//
//  state | meaning
//  IDLE  | no window open; first accepted element opens one
//  ACCUM | window open, tracking best value/index/count
//  HOLD  | result presented on out_*, waiting for out_ready
module max_pool_stream #(
    parameter int DATA_W = 32,
    parameter int MAX_LEN = 256,
    parameter int SIGNED = 1,
    localparam int IDX_W = $clog2(MAX_LEN),
    localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              mode_min,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] best, best_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              mode, mode_nxt;
    logic              accept, load, close, greater, less, better;

    assign in_ready  = (state != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    if (SIGNED != 0) begin : g_signed
        assign greater = $signed(in_data) > $signed(best);
        assign less    = $signed(in_data) < $signed(best);
    end else begin : g_unsigned
        assign greater = in_data > best;
        assign less    = in_data < best;
    end

    // strict compare: ties keep the earlier index
    assign better = mode ? less : greater;

    // a fresh window opens from IDLE, or from HOLD when the result is taken the same cycle
    assign load = accept && (state != ACCUM);

    always_comb begin
        state_nxt = state;
        best_nxt  = best;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        mode_nxt  = mode;
        close     = 1'b0;
        case (state)
            IDLE: ;
            ACCUM: begin
                if (accept) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (better) begin
                        best_nxt = in_data;
                        idx_nxt  = cnt[IDX_W-1:0];
                    end
                    if (in_last || (cnt == LAST_CNT)) begin
                        state_nxt = HOLD;
                        close     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            best_nxt  = in_data;
            idx_nxt   = '0;
            cnt_nxt   = CNT_W'(1);
            mode_nxt  = mode_min;
            state_nxt = in_last ? HOLD : ACCUM;
            close     = in_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            best      <= '0;
            idx       <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_count <= '0;
        end else begin
            state <= state_nxt;
            best  <= best_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            mode  <= mode_nxt;
            if (close) begin
                out_data  <= best_nxt;
                out_index <= idx_nxt;
                out_count <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: three instances (signed, unsigned, MAX_LEN=4) on a shared
// input stream, directed cases plus random traffic against a window-list reference model.
module tb_max_pool_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        mode_min = 1'b0;
    logic        out_ready = 1'b1;

    logic [31:0] s_data, u_data, f_data;
    logic [7:0]  s_index, u_index;
    logic [1:0]  f_index;
    logic [8:0]  s_count, u_count;
    logic [2:0]  f_count;
    logic        s_valid, u_valid, f_valid;
    logic        s_ready, u_ready, f_ready;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    max_pool_stream #(.DATA_W(32), .MAX_LEN(256), .SIGNED(1)) u_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(s_ready),
        .in_last(in_last), .mode_min(mode_min), .out_data(s_data), .out_index(s_index),
        .out_count(s_count), .out_valid(s_valid), .out_ready(out_ready));

    max_pool_stream #(.DATA_W(32), .MAX_LEN(256), .SIGNED(0)) u_u (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(u_ready),
        .in_last(in_last), .mode_min(mode_min), .out_data(u_data), .out_index(u_index),
        .out_count(u_count), .out_valid(u_valid), .out_ready(out_ready));

    max_pool_stream #(.DATA_W(32), .MAX_LEN(4), .SIGNED(1)) u_f (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(f_ready),
        .in_last(in_last), .mode_min(mode_min), .out_data(f_data), .out_index(f_index),
        .out_count(f_count), .out_valid(f_valid), .out_ready(out_ready));

    logic [31:0] o_data [3];
    logic [7:0]  o_idx [3];
    logic [8:0]  o_cnt [3];
    logic        o_valid [3];
    logic        i_ready [3];

    assign o_data[0] = s_data;  assign o_idx[0] = s_index;        assign o_cnt[0] = s_count;
    assign o_data[1] = u_data;  assign o_idx[1] = u_index;        assign o_cnt[1] = u_count;
    assign o_data[2] = f_data;  assign o_idx[2] = {6'b0, f_index}; assign o_cnt[2] = {6'b0, f_count};
    assign o_valid[0] = s_valid; assign o_valid[1] = u_valid; assign o_valid[2] = f_valid;
    assign i_ready[0] = s_ready; assign i_ready[1] = u_ready; assign i_ready[2] = f_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: list of accepted elements per instance, resolved when the window closes
    int          len_of [3] = '{256, 256, 4};
    bit          sgn_of [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] win_d [3][256];
    int          win_n [3];
    bit          win_m [3];
    bit          exp_have [3];
    logic [31:0] exp_d [3];
    int          exp_i [3];
    int          exp_c [3];
    bit          due [3];

    function automatic longint val(input logic [31:0] x, input bit s);
        return s ? longint'($signed(x)) : longint'({32'h0, x});
    endfunction

    function automatic void pick(input int i, output logic [31:0] d, output int k);
        longint bv, v;
        d  = win_d[i][0];
        k  = 0;
        bv = val(d, sgn_of[i]);
        for (int j = 1; j < win_n[i]; j++) begin
            v = val(win_d[i][j], sgn_of[i]);
            if (win_m[i] ? (v < bv) : (v > bv)) begin
                bv = v;
                k  = j;
                d  = win_d[i][j];
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [31:0] pd;
        int pk;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                win_n[i] = 0;
                exp_have[i] = 1'b0;
                due[i] = 1'b0;
            end else begin
                if (due[i]) chk($sformatf("latency%0d", i), 64'(o_valid[i]), 64'd1);
                due[i] = 1'b0;
                if (o_valid[i] && !out_ready) chk($sformatf("hold_ready%0d", i), 64'(i_ready[i]), 64'd0);
                if (o_valid[i] && out_ready) begin
                    if (exp_have[i]) begin
                        chk($sformatf("res_data%0d", i), 64'(o_data[i]), 64'(exp_d[i]));
                        chk($sformatf("res_idx%0d", i), 64'(o_idx[i]), 64'(exp_i[i]));
                        chk($sformatf("res_cnt%0d", i), 64'(o_cnt[i]), 64'(exp_c[i]));
                        exp_have[i] = 1'b0;
                    end else begin
                        chk($sformatf("spurious_valid%0d", i), 64'(o_valid[i]), 64'd0);
                    end
                end
                if (in_valid && i_ready[i]) begin
                    if (exp_have[i]) chk($sformatf("accept_in_hold%0d", i), 64'(i_ready[i]), 64'd0);
                    if (win_n[i] == 0) win_m[i] = mode_min;
                    win_d[i][win_n[i]] = in_data;
                    win_n[i]++;
                    if (in_last || win_n[i] == len_of[i]) begin
                        pick(i, pd, pk);
                        exp_d[i] = pd;
                        exp_i[i] = pk;
                        exp_c[i] = win_n[i];
                        exp_have[i] = 1'b1;
                        due[i] = 1'b1;
                        win_n[i] = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit last, input bit mm);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode_min = mm;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_d;
        reset = 1'b0;
        step();
        step();
        chk("rst_data", 64'(s_data), 64'd0);
        chk("rst_valid", 64'(s_valid), 64'd0);
        chk("rst_count", 64'(s_count), 64'd0);
        reset = 1'b1;
        step();
        chk("rst_ready", 64'(s_ready), 64'd1);

        // T1 plain max; the MAX_LEN=4 instance sees in_last on its auto-close element
        send(32'h0000_8000, 0, 0);
        send(32'h0003_8000, 0, 0);
        send(32'h0002_8000, 0, 0);
        send(32'h0001_8000, 1, 0);
        chk("t1_valid", 64'(s_valid), 64'd1);
        chk("t1_data", 64'(s_data), 64'h0003_8000);
        chk("t1_idx", 64'(s_index), 64'd1);
        chk("t1_cnt", 64'(s_count), 64'd4);
        chk("t1_f_cnt", 64'(f_count), 64'd4);
        idle();
        step();
        chk("t1_single_close", 64'(f_valid), 64'd0);

        // T2 signed vs unsigned
        send(32'hFFFE_0000, 0, 0);
        send(32'hFFFD_0000, 0, 0);
        send(32'h0000_0000, 0, 0);
        send(32'hFFFF_0000, 1, 0);
        chk("t2_s_data", 64'(s_data), 64'h0);
        chk("t2_s_idx", 64'(s_index), 64'd2);
        chk("t2_u_data", 64'(u_data), 64'hFFFF_0000);
        chk("t2_u_idx", 64'(u_index), 64'd3);
        idle();
        step();

        // T3 min mode, ties, mode change mid-window
        send(32'h0004_0000, 0, 1);
        send(32'h0003_0000, 0, 1);
        send(32'h0002_0000, 0, 1);
        send(32'h0001_0000, 1, 1);
        chk("t3_min_data", 64'(s_data), 64'h0001_0000);
        chk("t3_min_idx", 64'(s_index), 64'd3);
        send(32'h0002_0000, 0, 0);
        send(32'h0005_0000, 0, 0);
        send(32'h0005_0000, 1, 0);
        chk("t3_tie_data", 64'(s_data), 64'h0005_0000);
        chk("t3_tie_idx", 64'(s_index), 64'd1);
        send(32'h0001_0000, 0, 0);
        send(32'h0003_0000, 0, 1);
        send(32'h0002_0000, 1, 1);
        chk("t3_mode_data", 64'(s_data), 64'h0003_0000);
        chk("t3_mode_idx", 64'(s_index), 64'd1);
        idle();
        step();

        // T4 auto-close on the MAX_LEN=4 instance
        for (int k = 1; k <= 6; k++) begin
            send(32'(k) << 16, k == 6, 0);
            if (k == 4) begin
                chk("t4_a_data", 64'(f_data), 64'h0004_0000);
                chk("t4_a_idx", 64'(f_index), 64'd3);
                chk("t4_a_cnt", 64'(f_count), 64'd4);
            end
        end
        chk("t4_b_data", 64'(f_data), 64'h0006_0000);
        chk("t4_b_idx", 64'(f_index), 64'd1);
        chk("t4_b_cnt", 64'(f_count), 64'd2);
        idle();
        step();

        // T5 backpressure
        out_ready = 1'b0;
        send(32'h0001_0000, 0, 0);
        send(32'h0007_0000, 1, 0);
        hold_d = s_data;
        chk("t5_hold_data", 64'(hold_d), 64'h0007_0000);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = 32'h0042_0000 + 32'(k);
            step();
            chk("t5_stable_valid", 64'(s_valid), 64'd1);
            chk("t5_stable_data", 64'(s_data), 64'(hold_d));
            chk("t5_stable_cnt", 64'(s_count), 64'd2);
            chk("t5_ready_low", 64'(s_ready), 64'd0);
        end
        out_ready = 1'b1;
        send(32'h0009_0000, 0, 0);
        chk("t5_consumed", 64'(s_valid), 64'd0);
        send(32'h0002_0000, 1, 0);
        chk("t5_new_data", 64'(s_data), 64'h0009_0000);
        chk("t5_new_idx", 64'(s_index), 64'd0);
        chk("t5_new_cnt", 64'(s_count), 64'd2);
        idle();
        step();

        // T6 reset mid-window
        send(32'h7FFF_0000, 0, 0);
        send(32'h7FFE_0000, 0, 0);
        idle();
        reset = 1'b0;
        #1;
        chk("t6_data", 64'(s_data), 64'h0);
        chk("t6_idx", 64'(s_index), 64'h0);
        chk("t6_cnt", 64'(s_count), 64'h0);
        chk("t6_valid", 64'(s_valid), 64'h0);
        chk("t6_ready", 64'(s_ready), 64'h1);
        step();
        step();
        reset = 1'b1;
        send(32'h0001_0000, 0, 0);
        send(32'h0002_0000, 0, 0);
        send(32'h0003_0000, 1, 0);
        chk("t6_new_data", 64'(s_data), 64'h0003_0000);
        chk("t6_new_idx", 64'(s_index), 64'd2);
        chk("t6_new_cnt", 64'(s_count), 64'd3);
        idle();
        step();

        // random traffic, checked by the reference model at each handshake
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 2))
                0: in_data = 32'($urandom_range(0, 7)) << 16;
                1: in_data = 32'hFFFF_0000 - (32'($urandom_range(0, 3)) << 16);
                default: in_data = $urandom;
            endcase
            in_last   = ($urandom_range(0, 9) == 0);
            mode_min  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 64'(exp_have[i]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
